gf180mcu_fd_sc_mcu7t5v0__clkdiv_gen: RTL and testbench



---
 rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_gen_if.sv | 21 ++
 rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_gen.sv | 101 ++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_gen_if.sv
// Control/status bundle for the programmable clock divider.
// TICK is present only when GF180MCU_CLKDIV_TICK_EN is defined.
interface gf180mcu_fd_sc_mcu7t5v0__clkdiv_gen_if #(
    parameter int WIDTH = 8
);
    logic             EN;
    logic             LOAD;
    logic [WIDTH-1:0] DIV;
    logic             Z;
    logic             PEND;
    logic             ACK;
`ifdef GF180MCU_CLKDIV_TICK_EN
    logic             TICK;

    modport master (output EN, LOAD, DIV, input Z, PEND, ACK, TICK);
    modport slave  (input EN, LOAD, DIV, output Z, PEND, ACK, TICK);
`else
    modport master (output EN, LOAD, DIV, input Z, PEND, ACK);
    modport slave  (input EN, LOAD, DIV, output Z, PEND, ACK);
`endif
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_gen.sv
// Programmable integer clock divider with a registered, glitch-free output.
// Optional TICK (pulse on each Z rise) is built when GF180MCU_CLKDIV_TICK_EN is defined.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_gen #(
    parameter int WIDTH = 8
) (
    input  logic CLK,
    input  logic RST,
    gf180mcu_fd_sc_mcu7t5v0__clkdiv_gen_if.slave bus
);
    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DRAIN} state_t;

    state_t           state;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] ratio;
    logic [WIDTH-1:0] pend_ratio;
    logic             pend;
    logic             z;
    logic             ack;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH:0]   high_len;
    logic             wrap;
    logic             z_cnt;
    logic             z_d;
    logic             apply;

    function automatic logic [WIDTH-1:0] clamp_ratio(input logic [WIDTH-1:0] d);
        return (d < WIDTH'(2)) ? WIDTH'(2) : d;
    endfunction

    assign wrap     = (p == ratio - WIDTH'(1));
    assign p_next   = wrap ? '0 : p + WIDTH'(1);
    assign high_len = ({1'b0, ratio} + (WIDTH+1)'(1)) >> 1;
    assign z_cnt    = ({1'b0, p_next} < high_len);
    // New ratios land only on a period boundary, or right away when stopped.
    assign apply    = pend && ((state == ST_STOP) || wrap);

    always_comb begin
        z_d = z_cnt;
        case (state)
            ST_STOP:  z_d = bus.EN;
            ST_DRAIN: if (!bus.EN && wrap) z_d = 1'b0;
            default:  z_d = z_cnt;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_STOP;
            p     <= '0;
            ratio <= WIDTH'(2);
            pend  <= 1'b0;
            z     <= 1'b0;
            ack   <= 1'b0;
        end else begin
            z   <= z_d;
            ack <= apply;
            if (apply) ratio <= pend_ratio;
            if (bus.LOAD) pend <= 1'b1;
            else if (apply) pend <= 1'b0;
            case (state)
                ST_STOP: begin
                    p <= '0;
                    if (bus.EN) state <= ST_RUN;
                end
                ST_RUN: begin
                    p <= p_next;
                    if (!bus.EN) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    p <= p_next;
                    if (bus.EN) state <= ST_RUN;
                    else if (wrap) state <= ST_STOP;
                end
                default: begin
                    state <= ST_STOP;
                    p     <= '0;
                end
            endcase
        end
    end

    // Pending ratio value is data; only its flag is reset.
    always_ff @(posedge CLK) begin
        if (bus.LOAD) pend_ratio <= clamp_ratio(bus.DIV);
    end

    assign bus.Z    = z;
    assign bus.PEND = pend;
    assign bus.ACK  = ack;

`ifdef GF180MCU_CLKDIV_TICK_EN
    logic tick;

    always_ff @(posedge CLK) begin
        if (RST) tick <= 1'b0;
        else     tick <= z_d & ~z;
    end

    assign bus.TICK = tick;
`endif
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_gen.sv
// Scoreboard bench for the clock divider: a period-level waveform model predicts
// Z/PEND/ACK(/TICK) per edge, a monitor compares on the falling edge.
module tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_gen;
    localparam int W = 8;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    gf180mcu_fd_sc_mcu7t5v0__clkdiv_gen_if #(.WIDTH(W)) bus ();

    gf180mcu_fd_sc_mcu7t5v0__clkdiv_gen #(.WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic z;
        logic pend;
        logic ack;
        logic tick;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    // Reference model: the current period is a queue of remaining Z samples.
    bit   m_active;
    bit   m_draining;
    bit   m_pend;
    bit   m_z;
    int   m_ratio;
    int   m_pval;
    bit   wave[$];

    task automatic start_period();
        wave.delete();
        for (int i = 0; i < m_ratio; i++) wave.push_back(i < (m_ratio + 1) / 2);
    endtask

    task automatic model_step(input bit en, input bit ld, input int div, input bit rst);
        bit   z_new;
        bit   ack;
        exp_t e;
        z_new = 1'b0;
        ack   = 1'b0;
        if (rst) begin
            m_active   = 1'b0;
            m_draining = 1'b0;
            m_ratio    = 2;
            m_pend     = 1'b0;
            m_z        = 1'b0;
            wave.delete();
        end else begin
            if (!m_active) begin
                if (m_pend) begin
                    m_ratio = m_pval;
                    m_pend  = 1'b0;
                    ack     = 1'b1;
                end
                if (en) begin
                    m_active   = 1'b1;
                    m_draining = 1'b0;
                    start_period();
                    z_new = wave.pop_front();
                end
            end else if (wave.size() == 0) begin
                if (m_pend) begin
                    m_ratio = m_pval;
                    m_pend  = 1'b0;
                    ack     = 1'b1;
                end
                if (m_draining && !en) begin
                    m_active = 1'b0;
                    wave.delete();
                end else begin
                    start_period();
                    z_new      = wave.pop_front();
                    m_draining = !en;
                end
            end else begin
                z_new      = wave.pop_front();
                m_draining = !en;
            end
            if (ld) begin
                m_pval = (div < 2) ? 2 : div;
                m_pend = 1'b1;
            end
        end
        e.z    = z_new;
        e.pend = m_pend;
        e.ack  = ack;
        e.tick = z_new && !m_z;
        m_z    = z_new;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b, want %b", name, cyc, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc++;
            check("Z", bus.Z, e.z);
            check("PEND", bus.PEND, e.pend);
            check("ACK", bus.ACK, e.ack);
`ifdef GF180MCU_CLKDIV_TICK_EN
            check("TICK", bus.TICK, e.tick);
`endif
        end
    end

    task automatic step(input bit en, input bit ld, input int div, input bit rst);
        logic [W-1:0] d;
        d        = W'(div);
        RST      = rst;
        bus.EN   = en;
        bus.LOAD = ld;
        bus.DIV  = d;
        model_step(en, ld, int'(d), rst);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) step(en, 1'b0, 0, 1'b0);
    endtask

    initial begin
        bit en_r;
        RST      = 1'b1;
        bus.EN   = 1'b0;
        bus.LOAD = 1'b0;
        bus.DIV  = '0;

        step(0, 0, 0, 1);
        step(1, 1, 9, 1);
        run(8, 1);                 // default ratio 2
        run(4, 0);
        step(0, 1, 5, 0);          // load while stopped
        run(12, 1);
        step(1, 1, 3, 0);
        run(7, 1);
        step(1, 1, 4, 0);          // load mid-period at ratio 3
        run(12, 1);
        step(1, 1, 6, 0);
        run(7, 1);
        run(10, 0);                // drain to stop
        run(7, 1);
        run(3, 0);                 // drop then re-raise before wrap
        run(10, 1);
        step(1, 1, 0, 0);
        run(8, 1);
        step(1, 1, 1, 0);
        run(8, 1);
        step(1, 1, 255, 0);
        run(520, 1);
        run(260, 0);
        step(0, 1, 7, 0);
        step(0, 1, 3, 0);          // overwrite while pending
        run(10, 1);
        step(1, 1, 9, 0);
        step(1, 1, 7, 0);
        run(2, 1);
        step(1, 0, 0, 1);          // reset with a ratio pending
        run(20, 1);

        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) en_r = !en_r;
            step(en_r,
                 $urandom_range(0, 19) == 0,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9)),
                 $urandom_range(0, 599) == 0);
        end

        repeat (2) @(negedge CLK);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
